// File: rtl/usb_pkg.sv
// Shared USB receive-path definitions: PID codes, classifier FSM states and CRC5 constants.
package usb_pkg;

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidSof   = 4'b0101;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidPing  = 4'b0100;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;
    localparam logic [3:0] PidData2 = 4'b0111;
    localparam logic [3:0] PidMdata = 4'b1111;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;
    localparam logic [3:0] PidNyet  = 4'b0110;

    typedef enum logic [2:0] {
        StIdle,
        StTok1,
        StTok2,
        StData,
        StDrop
    } state_e;

    // x^5 + x^2 + 1, shifted towards bit 4, fed LSB first
    localparam logic [4:0] Crc5Poly     = 5'h05;
    localparam logic [4:0] Crc5Init     = 5'h1F;
    localparam logic [4:0] Crc5Residual = 5'h0C;

    function automatic logic is_token_pid(input logic [3:0] pid);
        return pid inside {PidOut, PidIn, PidSof, PidSetup, PidPing};
    endfunction

    function automatic logic is_data_pid(input logic [3:0] pid);
        return pid inside {PidData0, PidData1, PidData2, PidMdata};
    endfunction

    function automatic logic is_hs_pid(input logic [3:0] pid);
        return pid inside {PidAck, PidNak, PidStall, PidNyet};
    endfunction

endpackage

// File: rtl/usb_crc5_byte.sv
// Combinational USB CRC5 update over one byte, bits consumed LSB first.
module usb_crc5_byte
    import usb_pkg::*;
(
    input  logic [4:0] crc_in,
    input  logic [7:0] data,
    output logic [4:0] crc_out
);

    always_comb begin
        logic [4:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[4] ^ data[i]) begin
                c = {c[3:0], 1'b0} ^ Crc5Poly;
            end else begin
                c = {c[3:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb_rx_pid_crc5.sv
// Receive-path packet classifier: PID decode, token CRC5/address check, handshake report and
// DATA packet forwarding through a one-entry slice. Optional macro: USB_PID_CHECK_EN.
module usb_rx_pid_crc5
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phy_rx_sop,
    input  logic        phy_rx_eop,
    input  logic        phy_rx_valid,
    output logic        phy_rx_ready,
    input  logic [7:0]  phy_rx_data,
    input  logic [6:0]  dev_addr,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_token_valid,
    output logic [3:0]  rx_pid,
    output logic [6:0]  rx_addr,
    output logic [3:0]  rx_endp,
    output logic [10:0] rx_frame_num,
    output logic        rx_hs_valid,
    output logic        rx_crc5_err,
    output logic        rx_pkt_err,
    output logic        rx_pid_err
);

    state_e      state_q, state_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [3:0]  tok_pid_q, tok_pid_d;

    logic        slc_valid_q, slc_valid_d;
    logic        slc_sop_q, slc_sop_d;
    logic        slc_eop_q, slc_eop_d;
    logic [7:0]  slc_data_q, slc_data_d;

    logic        tok_valid_q, tok_valid_d;
    logic        hs_valid_q, hs_valid_d;
    logic        crc5_err_q, crc5_err_d;
    logic        pkt_err_q, pkt_err_d;
    logic        pid_err_q, pid_err_d;
    logic [3:0]  pid_q, pid_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  endp_q, endp_d;
    logic [10:0] frame_q, frame_d;

    logic        acc;
    logic        pid_bad;
    logic [3:0]  pid;
    logic [10:0] tok_field;
    logic [4:0]  crc_mid, crc_res;
    logic        crc_good;

    assign phy_rx_ready = !slc_valid_q || rx_ready;
    assign acc          = phy_rx_valid && phy_rx_ready;
    assign pid          = phy_rx_data[3:0];
    assign tok_field    = {phy_rx_data[2:0], byte1_q};

`ifdef USB_PID_CHECK_EN
    assign pid_bad = phy_rx_data[7:4] != ~phy_rx_data[3:0];
`else
    assign pid_bad = 1'b0;
`endif

    usb_crc5_byte u_crc_byte1 (
        .crc_in  (Crc5Init),
        .data    (byte1_q),
        .crc_out (crc_mid)
    );

    usb_crc5_byte u_crc_byte2 (
        .crc_in  (crc_mid),
        .data    (phy_rx_data),
        .crc_out (crc_res)
    );

    assign crc_good = crc_res == Crc5Residual;

    always_comb begin
        state_d     = state_q;
        byte1_d     = byte1_q;
        tok_pid_d   = tok_pid_q;
        slc_valid_d = slc_valid_q && !rx_ready;
        slc_sop_d   = slc_sop_q;
        slc_eop_d   = slc_eop_q;
        slc_data_d  = slc_data_q;
        tok_valid_d = 1'b0;
        hs_valid_d  = 1'b0;
        crc5_err_d  = 1'b0;
        pkt_err_d   = 1'b0;
        pid_err_d   = 1'b0;
        pid_d       = pid_q;
        addr_d      = addr_q;
        endp_d      = endp_q;
        frame_d     = frame_q;

        if (acc && phy_rx_sop) begin
            // A sop outside IDLE aborts the packet in flight; the new PID still decodes now.
            if (state_q != StIdle) begin
                pkt_err_d = 1'b1;
            end
            if (pid_bad) begin
                pid_err_d = 1'b1;
                state_d   = phy_rx_eop ? StIdle : StDrop;
            end else if (is_token_pid(pid)) begin
                tok_pid_d = pid;
                state_d   = StTok1;
            end else if (is_data_pid(pid)) begin
                slc_valid_d = 1'b1;
                slc_sop_d   = 1'b1;
                slc_eop_d   = phy_rx_eop;
                slc_data_d  = phy_rx_data;
                state_d     = phy_rx_eop ? StIdle : StData;
            end else if (is_hs_pid(pid)) begin
                if (phy_rx_eop) begin
                    hs_valid_d = 1'b1;
                    pid_d      = pid;
                    state_d    = StIdle;
                end else begin
                    pkt_err_d = 1'b1;
                    state_d   = StDrop;
                end
            end else begin
                state_d = phy_rx_eop ? StIdle : StDrop;
            end
        end else if (acc) begin
            case (state_q)
                StIdle: ;
                StTok1: begin
                    if (phy_rx_eop) begin
                        pkt_err_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        byte1_d = phy_rx_data;
                        state_d = StTok2;
                    end
                end
                StTok2: begin
                    if (!phy_rx_eop) begin
                        pkt_err_d = 1'b1;
                        state_d   = StDrop;
                    end else begin
                        state_d = StIdle;
                        if (!crc_good) begin
                            crc5_err_d = 1'b1;
                        end else begin
                            pid_d = tok_pid_q;
                            if (tok_pid_q == PidSof) begin
                                frame_d     = tok_field;
                                tok_valid_d = 1'b1;
                            end else begin
                                addr_d      = tok_field[6:0];
                                endp_d      = tok_field[10:7];
                                tok_valid_d = tok_field[6:0] == dev_addr;
                            end
                        end
                    end
                end
                StData: begin
                    slc_valid_d = 1'b1;
                    slc_sop_d   = 1'b0;
                    slc_eop_d   = phy_rx_eop;
                    slc_data_d  = phy_rx_data;
                    if (phy_rx_eop) begin
                        state_d = StIdle;
                    end
                end
                StDrop: begin
                    if (phy_rx_eop) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            byte1_q     <= 8'h00;
            tok_pid_q   <= 4'h0;
            slc_valid_q <= 1'b0;
            slc_sop_q   <= 1'b0;
            slc_eop_q   <= 1'b0;
            slc_data_q  <= 8'h00;
            tok_valid_q <= 1'b0;
            hs_valid_q  <= 1'b0;
            crc5_err_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            pid_err_q   <= 1'b0;
            pid_q       <= 4'h0;
            addr_q      <= 7'h00;
            endp_q      <= 4'h0;
            frame_q     <= 11'h000;
        end else begin
            state_q     <= state_d;
            byte1_q     <= byte1_d;
            tok_pid_q   <= tok_pid_d;
            slc_valid_q <= slc_valid_d;
            slc_sop_q   <= slc_sop_d;
            slc_eop_q   <= slc_eop_d;
            slc_data_q  <= slc_data_d;
            tok_valid_q <= tok_valid_d;
            hs_valid_q  <= hs_valid_d;
            crc5_err_q  <= crc5_err_d;
            pkt_err_q   <= pkt_err_d;
            pid_err_q   <= pid_err_d;
            pid_q       <= pid_d;
            addr_q      <= addr_d;
            endp_q      <= endp_d;
            frame_q     <= frame_d;
        end
    end

    assign rx_valid       = slc_valid_q;
    assign rx_sop         = slc_sop_q;
    assign rx_eop         = slc_eop_q;
    assign rx_data        = slc_data_q;
    assign rx_token_valid = tok_valid_q;
    assign rx_hs_valid    = hs_valid_q;
    assign rx_crc5_err    = crc5_err_q;
    assign rx_pkt_err     = pkt_err_q;
    assign rx_pid_err     = pid_err_q;
    assign rx_pid         = pid_q;
    assign rx_addr        = addr_q;
    assign rx_endp        = endp_q;
    assign rx_frame_num   = frame_q;

endmodule
